circuito_sweep_ctrl: RTL and testbench
======================================

Name: circuito_sweep_ctrl

Overview:
Sequencer that exhaustively drives the 3-input combinational circuit (inputs a, b, c; outputs s1, s2) through all 8 input vectors. It waits a programmable settle time per vector and captures both outputs into 8-bit truth-table registers. It sits between a start/done host handshake and one circuitoD instance, and replaces hand-written stimulus with on-chip self-characterisation.

Parameters:
HOLD_CYCLES, 4, settle cycles between applying a vector and sampling s1/s2; legal range 1..255; 0 rejected by elaboration-time assertion.

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  sweep request; sampled only in IDLE
s1  input  1  circuitoD output s1
s2  input  1  circuitoD output s2
exp_s1  input  8  expected s1 truth table, bit i = vector i (used only with COMPARE_EN)
exp_s2  input  8  expected s2 truth table (used only with COMPARE_EN)
a  output  1  stimulus MSB, vector bit 2
b  output  1  stimulus, vector bit 1
c  output  1  stimulus LSB, vector bit 0
busy  output  1  high from the cycle after start is accepted until DONE
done  output  1  one-cycle pulse when the sweep completes
tt_s1  output  8  captured s1 table, bit i = s1 for vector i
tt_s2  output  8  captured s2 table
pass  output  1  comparison result (COMPARE_EN only; else constant 0)

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE; vec=0; a=b=c=0; busy=0; done=0; tt_s1=tt_s2=8'h00; pass=0.
- All outputs are registered. {a,b,c} always equals vec.
- FSM states: IDLE, APPLY, SETTLE, CAPTURE, DONE.
- IDLE: start=1 -> APPLY; vec<=0; tt_s1/tt_s2 cleared; pass cleared; busy<=1. start=0 -> stay in IDLE.
- APPLY (1 cycle): drive vec on a/b/c; load settle counter with HOLD_CYCLES-1 -> SETTLE.
- SETTLE: decrement each cycle; counter==0 -> CAPTURE.
- CAPTURE (1 cycle): tt_s1[vec]<=s1, tt_s2[vec]<=s2. If vec==7 -> DONE; else vec<=vec+1 (3-bit, no wrap reached) -> APPLY.
- DONE (1 cycle): done=1, busy<=0, a/b/c hold 3'b111; -> IDLE. tt_* hold until the next accepted start.
- Cycles per vector = HOLD_CYCLES+2. With the default, the sweep takes 48 cycles from the APPLY entry to the last CAPTURE, and done asserts on the 49th.
- start while busy or in DONE: ignored, not queued. start held high continuously: a new sweep starts on the first IDLE cycle after DONE.
- s1/s2 are sampled only in CAPTURE. Glitches during SETTLE have no effect.
- Reset mid-sweep: immediate return to reset values; partial tables are discarded.

Optional Feature:
COMPARE_EN. When defined, in DONE pass<=(tt_s1_final==exp_s1)&&(tt_s2_final==exp_s2), where *_final includes the vector-7 capture. pass holds until the next accepted start or reset. exp_* are sampled in DONE only. When not defined, pass is tied to 0, exp_* are unused, and no comparator logic is generated.

Decomposition:
- Package circuito_pkg: state enum sweep_state_t {IDLE, APPLY, SETTLE, CAPTURE, DONE}; constants NUM_INPUTS=3, NUM_VECTORS=8; typedef vec_t = logic[2:0].
- Sub-module circuito_settle_timer: loadable down-counter, width $clog2(HOLD_CYCLES+1), with load/zero flags.
- FSM, vector counter and capture registers stay in circuito_sweep_ctrl.

Test Plan:
1. Reset then idle: rst pulse, start=0 for 20 cycles -> a/b/c=0, busy=0, done=0, tt_s1=tt_s2=8'h00.
2. Full sweep against a behavioural DUT (s1=a&b, s2=b^c), HOLD_CYCLES=4, 1-cycle start -> done pulses exactly 49 cycles after start is accepted; tt_s1=8'hC0, tt_s2=8'h66; a/b/c step 000..111 every 6 cycles.
3. start pulses at cycles 10 and 30 of a sweep -> no restart; a single done; tables identical to scenario 2.
4. Async rst asserted mid-SETTLE of vector 5 -> same edge: busy=0, a/b/c=0, tt_*=0. A new start then completes a clean sweep.
5. HOLD_CYCLES=1, with s1 glitching to 1 only during SETTLE cycles -> tt_s1 reflects only the CAPTURE-cycle values; each vector takes 3 cycles.
6. COMPARE_EN defined: exp_s1=8'hC0, exp_s2=8'h66 -> pass=1 after DONE. Second sweep with exp_s2=8'h67 -> pass=0. pass clears at the next start.

Source files
------------

// File: rtl/circuito_pkg.sv
// circuito_pkg: shared types and constants for the circuitoD sweep sequencer.
package circuito_pkg;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      CAPTURE,
      DONE
   } sweep_state_t;

   localparam int NUM_INPUTS  = 3;
   localparam int NUM_VECTORS = 8;

   typedef logic [NUM_INPUTS-1:0] vec_t;

   localparam vec_t LAST_VEC = vec_t'(NUM_VECTORS - 1);

endpackage

// File: rtl/circuito_settle_timer.sv
// circuito_settle_timer: loadable down-counter that paces the settle window.
// Loads HOLD_CYCLES-1, counts down while enabled, flags zero.
module circuito_settle_timer
   import circuito_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic en_i,
   output logic zero_o
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CW'(HOLD_CYCLES - 1);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/circuito_sweep_ctrl.sv
// circuito_sweep_ctrl: drives circuitoD through all 8 vectors and captures s1/s2.
// Define COMPARE_EN to check the captured tables against exp_s1/exp_s2.
module circuito_sweep_ctrl
   import circuito_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   s1,
   input  logic                   s2,
   input  logic [NUM_VECTORS-1:0] exp_s1,
   input  logic [NUM_VECTORS-1:0] exp_s2,
   output logic                   a,
   output logic                   b,
   output logic                   c,
   output logic                   busy,
   output logic                   done,
   output logic [NUM_VECTORS-1:0] tt_s1,
   output logic [NUM_VECTORS-1:0] tt_s2,
   output logic                   pass
);

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
      $error("HOLD_CYCLES must be in 1..255");
   end

   sweep_state_t           state_q;
   vec_t                   vec_q;
   logic                   busy_q;
   logic                   done_q;
   logic [NUM_VECTORS-1:0] tt_s1_q;
   logic [NUM_VECTORS-1:0] tt_s2_q;
   logic                   tmr_zero;

   circuito_settle_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_timer (
      .clk_i (clk),
      .rst_i (rst),
      .load_i(state_q == APPLY),
      .en_i  (state_q == SETTLE),
      .zero_o(tmr_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tt_s1_q <= '0;
         tt_s2_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= APPLY;
                  vec_q   <= '0;
                  tt_s1_q <= '0;
                  tt_s2_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            APPLY: begin
               state_q <= SETTLE;
            end
            SETTLE: begin
               if (tmr_zero) begin
                  state_q <= CAPTURE;
               end
            end
            CAPTURE: begin
               tt_s1_q[vec_q] <= s1;
               tt_s2_q[vec_q] <= s2;
               if (vec_q == LAST_VEC) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  vec_q   <= vec_q + vec_t'(1);
                  state_q <= APPLY;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign {a, b, c} = vec_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign tt_s1     = tt_s1_q;
   assign tt_s2     = tt_s2_q;

`ifdef COMPARE_EN
   logic pass_q;

   // Tables are final in DONE, so the compare sees the vector-7 capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         pass_q <= 1'b0;
      end else if (state_q == DONE) begin
         pass_q <= (tt_s1_q == exp_s1) && (tt_s2_q == exp_s2);
      end
   end

   assign pass = pass_q;
`else
   logic unused_exp;

   assign unused_exp = ^{exp_s1, exp_s2};
   assign pass       = 1'b0;
`endif

endmodule

// File: tb/tb_circuito_sweep_ctrl.sv
// tb_circuito_sweep_ctrl: two sweepers (HOLD 4 and 1) against random truth tables,
// with a cycle-index reference model and a done-triggered scoreboard.
module tb_circuito_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] f1 = 8'hC0;
   logic [7:0] f2 = 8'h66;
   logic [7:0] e1 = 8'hC0;
   logic [7:0] e2 = 8'h66;
   longint     cyc = 0;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      logic [7:0] s1;
      logic [7:0] s2;
      longint     acc;
   } exp_t;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int H    = (g == 0) ? 4 : 1;
      localparam int LAST = 8 * (H + 2) + 1;

      logic       s1, s2, a, b, c, busy, done, pass;
      logic [7:0] tt1, tt2;
      logic       gl = 1'b0;

      bit         run_m = 1'b0;
      int         t_m = 0;
      exp_t       q[$];
      logic [7:0] cf1 = 8'h00, cf2 = 8'h00;
      logic [7:0] h1 = 8'h00, h2 = 8'h00;
      logic [2:0] habc = 3'd0;
      logic       pm = 1'b0;

      // Behavioural circuitoD: table lookup, s1 glitched during settle.
      assign s1 = f1[{a, b, c}] ^ gl;
      assign s2 = f2[{a, b, c}];

      circuito_sweep_ctrl #(
         .HOLD_CYCLES(H)
      ) dut (
         .clk   (clk),
         .rst   (rst),
         .start (start),
         .s1    (s1),
         .s2    (s2),
         .exp_s1(e1),
         .exp_s2(e2),
         .a     (a),
         .b     (b),
         .c     (c),
         .busy  (busy),
         .done  (done),
         .tt_s1 (tt1),
         .tt_s2 (tt2),
         .pass  (pass)
      );

      // t_m = 1-based cycle index of the sweep; LAST is the done cycle.
      always @(posedge clk) begin
         if (rst) begin
            run_m = 1'b0;
            t_m   = 0;
            q.delete();
            h1    = 8'h00;
            h2    = 8'h00;
            habc  = 3'd0;
            pm    = 1'b0;
         end else if (!run_m) begin
            if (start) begin
               run_m = 1'b1;
               t_m   = 1;
               cf1   = f1;
               cf2   = f2;
               pm    = 1'b0;
               q.push_back('{s1: f1, s2: f2, acc: cyc});
            end
         end else if (t_m == LAST) begin
            run_m = 1'b0;
            h1    = cf1;
            h2    = cf2;
            habc  = 3'd7;
`ifdef COMPARE_EN
            pm    = (cf1 == e1) && (cf2 == e2);
`else
            pm    = 1'b0;
`endif
         end else begin
            t_m++;
         end
      end

      always @(negedge clk) begin
         int ph;
         ph = (t_m - 1) % (H + 2);
         if (run_m && t_m != LAST && ph >= 1 && ph <= H) gl = 1'($urandom_range(0, 1));
         else gl = 1'b0;
      end

      always @(negedge clk) begin
         exp_t e;
         int   v;
         if (!rst) begin
            if (run_m) begin
               v = (t_m == LAST) ? 7 : (t_m - 1) / (H + 2);
               check($sformatf("i%0d busy", g), busy, 1);
               check($sformatf("i%0d abc t=%0d", g, t_m), {a, b, c}, v);
               check($sformatf("i%0d done t=%0d", g, t_m), done, t_m == LAST);
            end else begin
               check($sformatf("i%0d idle busy", g), busy, 0);
               check($sformatf("i%0d idle done", g), done, 0);
               check($sformatf("i%0d idle abc", g), {a, b, c}, habc);
               check($sformatf("i%0d idle tt_s1", g), tt1, h1);
               check($sformatf("i%0d idle tt_s2", g), tt2, h2);
            end
            check($sformatf("i%0d pass", g), pass, pm);
            if (done) begin
               if (q.size() == 0) begin
                  check($sformatf("i%0d unexpected done", g), 1, 0);
               end else begin
                  e = q.pop_front();
                  check($sformatf("i%0d sb tt_s1", g), tt1, e.s1);
                  check($sformatf("i%0d sb tt_s2", g), tt2, e.s2);
                  check($sformatf("i%0d sb latency", g), cyc - e.acc, LAST);
               end
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((g_inst[0].run_m || g_inst[1].run_m) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle timeout", n >= 300, 0);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Reference sweep with ignored start pulses mid-run.
      pulse_start();
      repeat (8) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      e2 = 8'h67;
      pulse_start();
      wait_idle();
      e2 = 8'h66;

      // Reset during SETTLE of vector 5 on the HOLD=4 instance.
      pulse_start();
      n = 0;
      while (g_inst[0].t_m != 33 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reach vec5 settle", n >= 100, 0);
      check("pre-rst busy", g_inst[0].busy, 1);
      #2 rst = 1'b1;
      #1;
      check("rst busy", g_inst[0].busy, 0);
      check("rst abc", {g_inst[0].a, g_inst[0].b, g_inst[0].c}, 0);
      check("rst tt_s1", g_inst[0].tt1, 0);
      check("rst tt_s2", g_inst[0].tt2, 0);
      check("rst done", g_inst[0].done, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      pulse_start();
      wait_idle();

      for (int it = 0; it < 12; it++) begin
         f1 = 8'($urandom);
         f2 = 8'($urandom);
         e1 = ($urandom_range(0, 1) == 1) ? f1 : f1 ^ (8'd1 << $urandom_range(0, 7));
         e2 = ($urandom_range(0, 1) == 1) ? f2 : f2 ^ (8'd1 << $urandom_range(0, 7));
         @(negedge clk);
         start = 1'b1;
         if (it == 5) begin
            repeat (120) @(negedge clk);
         end else begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            for (int k = 0; k < 60; k++) begin
               start = ($urandom_range(0, 7) == 0);
               @(negedge clk);
            end
         end
         start = 1'b0;
         wait_idle();
      end

      repeat (5) @(negedge clk);
      check("i0 pending", g_inst[0].q.size(), 0);
      check("i1 pending", g_inst[1].q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
